fp_div_result_stage: RTL and testbench
======================================

# fp_div_result_stage

Downstream completion stage for the single-precision IEEE-754 divider datapath. It accepts tagged operand pairs with a valid/ready handshake, and the parent drives the same operands into the divider. The block classifies each pair, tracks it through the divider's fixed 2-cycle latency, and merges the divider's mantissa with its own exponent and exception handling. Completed results are buffered in an in-order output FIFO under credit-based backpressure.

## Interface
- TAG_W, 4, width of request/result tag
- DEPTH, 4, output FIFO entries; also the credit limit (power of two, ≥2)
- DIV_LAT, 2, cycles from operands presented to the divider until its result is valid; fixed by the divider
- clk  in  1  rising-edge clock, shared with the divider
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  operand pair present
- req_ready  out  1  block can accept a pair this cycle
- req_a  in  32  dividend; parent also wires it to the divider's a1
- req_b  in  32  divisor; parent also wires it to the divider's b1
- req_tag  in  TAG_W  returned unchanged with the result
- div_c  in  32  divider output c
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer takes the head
- res_data  out  32  final quotient
- res_tag  out  TAG_W  tag of the head
- res_flags  out  4  {nv, dz, of, uf} of the head

## Operation
- Accept when req_valid && req_ready at a rising edge. The divider cannot stall, so backpressure is credit-based.
  - req_ready = (fifo_count + inflight) < DEPTH, combinational.
  - inflight = number of set valid bits in the delay line.
- Classify at accept, with e = exponent field and m = fraction field:
  - zero: e==0; denormals are flushed and treated as zero.
  - inf: e==255 && m==0.
  - nan: e==255 && m!=0.
  - normal: all other cases.
- Special result, checked in priority order:
  1. Any NaN, 0/0 or inf/inf → 0x7FC00000, nv=1.
  2. Finite nonzero/0 → {s,0xFF,0}, dz=1.
  3. inf/finite → {s,0xFF,0}.
  4. 0/x or finite/inf → {s,0x00,0}.
  - s = a[31]^b[31].
- Normal path:
  - Compute a 10-bit signed exponent: E = ea − eb + 127 − (ma_frac < mb_frac). This matches the divider's one-step normalisation, which applies when the dividend mantissa is smaller than the divisor mantissa.
  - E ≥ 255 → {s,0xFF,0}, of=1.
  - E ≤ 0 → {s,0x00,0}, uf=1.
  - Otherwise → {s, E[7:0], div_c[22:0]}. This is truncated quotient, with no rounding.
- Delay line: DIV_LAT stages. Each stage holds {valid, tag, special, special_result, flags, s, E}. It shifts every cycle unconditionally.
- At the last stage, a valid entry is combined with div_c and pushed into the FIFO that cycle.
  - The credit rule guarantees the FIFO is never full on a push.
- FIFO:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop leaves the count unchanged.
  - A pop on empty is ignored.
  - res_* present the head entry combinationally from storage.
  - Order is strictly request order.

## Timing
- Pair accepted in cycle T:
  - Divider registers operands at the end of T.
  - div_c is valid in T+DIV_LAT.
  - Push happens at the end of T+DIV_LAT.
  - res_valid rises in T+DIV_LAT+1 at the earliest.
- Throughput is one result per cycle when res_ready is held high.
- A credit returns in the cycle after a pop. A request accepted in that same cycle is legal.
- Reset, asynchronous:
  - Clears delay-line valid bits, FIFO pointers and count.
  - Outputs: res_valid=0, res_data=0, res_tag=0, res_flags=0, req_ready=1.
  - FIFO storage is not reset.
  - Reset mid-operation drops all in-flight and buffered results. Stale div_c values arriving afterwards are ignored because their valid bits are clear.

## Test plan
- 0x40C00000 / 0x40000000, tag 3, res_ready=1 → at T+3: res_data=0x40400000, tag 3, flags 0000.
- 0x3F800000 / 0x40400000 → 0x3EAAAAAA (truncated), flags 0000. Covers the normalisation-shift exponent path.
- Edge-case pairs:
  - 0x3F800000/0x00000000 → 0x7F800000, dz.
  - 0x00000000/0x00000000 → 0x7FC00000, nv.
  - 0xFF800000/0x40000000 → 0xFF800000, flags 0.
  - 0x40000000/0x7F800000 → 0x00000000.
- Overflow and underflow:
  - 0x7F000000/0x00800000 → 0x7F800000, of.
  - 0x00800000/0x7F000000 → 0x00000000, uf.
- res_ready=0, six back-to-back requests with tags 0–5:
  - Exactly four accepted; req_ready=0 from the cycle after the 4th accept.
  - Raise res_ready: tags 0,1,2,3 drain in order, one per cycle.
  - Tags 4,5 are accepted as credits return.
- Two requests in flight, pulse rst_n low for one cycle mid-flight:
  - res_valid stays 0 and no result ever emerges for the dropped tags.
  - req_ready=1 immediately after reset.
  - A fresh request completes with correct data.

Source files
------------

// File: rtl/fp_div_result_stage_if.sv
// Handshake bundle for fp_div_result_stage: tagged operand requests in,
// tagged quotient results out.
interface fp_div_result_stage_if #(parameter int TAG_W = 4);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic [3:0]       res_flags;

  modport master (
    output req_valid, req_a, req_b, req_tag, res_ready,
    input  req_ready, res_valid, res_data, res_tag, res_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag, res_ready,
    output req_ready, res_valid, res_data, res_tag, res_flags
  );
endinterface

// File: rtl/fp_div_result_stage.sv
// Completion stage for the fixed-latency fp32 divider: classifies operands, tracks
// them alongside the divider, merges its mantissa and buffers results in order.
module fp_div_result_stage #(
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int DIV_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          div_c,
  fp_div_result_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic              special;
    logic [31:0]       sres;
    logic [3:0]        flags;   // {nv, dz, of, uf}
    logic              s;
    logic signed [9:0] e;
  } stage_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [3:0]       flags;
    logic [31:0]      data;
  } ent_t;

  stage_t pipe_q [DIV_LAT];
  stage_t pipe_d [DIV_LAT];
  stage_t st_d, tail;
  ent_t   mem_q [DEPTH];
  ent_t   push_ent, head;

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    inflight;
  logic          accept, push, pop;
  logic          unused_div_hi;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s;

  assign unused_div_hi = ^div_c[31:23];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DIV_LAT; i++) inflight = inflight + 8'(pipe_q[i].vld);
  end

  // Credits cover both buffered results and those still inside the divider.
  assign bus.req_ready = (8'(cnt_q) + inflight) < 8'(DEPTH);
  assign accept        = bus.req_valid && bus.req_ready;

  assign ea = bus.req_a[30:23];
  assign eb = bus.req_b[30:23];
  assign fa = bus.req_a[22:0];
  assign fb = bus.req_b[22:0];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);
  assign s      = bus.req_a[31] ^ bus.req_b[31];

  always_comb begin
    st_d     = '0;
    st_d.vld = accept;
    st_d.tag = bus.req_tag;
    st_d.s   = s;
    // One-step normalisation in the divider when the dividend mantissa is smaller.
    st_d.e   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
             - $signed({9'd0, (fa < fb)});
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      st_d.special = 1'b1;
      st_d.sres    = 32'h7FC0_0000;
      st_d.flags   = 4'b1000;
    end else if (b_zero && !a_inf) begin
      st_d.special = 1'b1;
      st_d.sres    = {s, 8'hFF, 23'd0};
      st_d.flags   = 4'b0100;
    end else if (a_inf) begin
      st_d.special = 1'b1;
      st_d.sres    = {s, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      st_d.special = 1'b1;
      st_d.sres    = {s, 8'h00, 23'd0};
    end
  end

  always_comb begin
    pipe_d[0] = st_d;
    for (int i = 1; i < DIV_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIV_LAT; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < DIV_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign tail = pipe_q[DIV_LAT-1];
  assign push = tail.vld;
  assign pop  = bus.res_ready && (cnt_q != '0);

  always_comb begin
    push_ent       = '0;
    push_ent.tag   = tail.tag;
    if (tail.special) begin
      push_ent.data  = tail.sres;
      push_ent.flags = tail.flags;
    end else if (tail.e >= 10'sd255) begin
      push_ent.data  = {tail.s, 8'hFF, 23'd0};
      push_ent.flags = 4'b0010;
    end else if (tail.e <= 10'sd0) begin
      push_ent.data  = {tail.s, 8'h00, 23'd0};
      push_ent.flags = 4'b0001;
    end else begin
      push_ent.data  = {tail.s, tail.e[7:0], div_c[22:0]};
    end
  end

  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_ent;
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign head          = mem_q[rptr_q];
  assign bus.res_valid = (cnt_q != '0);
  assign bus.res_data  = bus.res_valid ? head.data  : '0;
  assign bus.res_tag   = bus.res_valid ? head.tag   : '0;
  assign bus.res_flags = bus.res_valid ? head.flags : '0;
endmodule

// File: tb/tb_fp_div_result_stage.sv
// Scoreboard bench for fp_div_result_stage with a behavioural 2-cycle divider model.
module tb_fp_div_result_stage;
  localparam int TAG_W = 4, DEPTH = 4, DIV_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] div_c;
  logic [63:0] d1, d2;

  always #5 clk = ~clk;

  fp_div_result_stage_if #(.TAG_W(TAG_W)) bus();

  fp_div_result_stage #(.TAG_W(TAG_W), .DEPTH(DEPTH), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .div_c(div_c), .bus(bus)
  );

  typedef logic [39:0] exp_t;  // {tag, flags, data}
  exp_t expq[$];
  int   tests = 0, fails = 0;
  bit   rnd_done;

  // Truncated quotient of the two significands, normalised to [1,2).
  function automatic logic [22:0] quot_frac(logic [31:0] a, logic [31:0] b);
    longint ma, mb, q;
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    q  = (ma >= mb) ? (ma << 23) / mb : (ma << 24) / mb;
    return q[22:0];
  endfunction

  // Divider: operands registered at the edge, result visible DIV_LAT cycles later.
  always @(posedge clk) begin
    d1 <= {bus.req_a, bus.req_b};
    d2 <= d1;
  end
  assign div_c = {9'h1A5, quot_frac(d2[63:32], d2[31:0])};

  function automatic exp_t ref_div(logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] tag);
    int ea, eb, e;
    bit az, bz, ai, bi, an, bn, s;
    logic [7:0] e8;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    az = (ea == 0); bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0); bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0); bn = (eb == 255) && (b[22:0] != 0);
    s  = a[31] ^ b[31];
    if (an || bn || (az && bz) || (ai && bi)) return {tag, 4'b1000, 32'h7FC00000};
    if (bz && !ai)                            return {tag, 4'b0100, s, 8'hFF, 23'd0};
    if (ai)                                   return {tag, 4'b0000, s, 8'hFF, 23'd0};
    if (az || bi)                             return {tag, 4'b0000, s, 8'h00, 23'd0};
    e = ea - eb + 127 - ((a[22:0] < b[22:0]) ? 1 : 0);
    if (e >= 255) return {tag, 4'b0010, s, 8'hFF, 23'd0};
    if (e <= 0)   return {tag, 4'b0001, s, 8'h00, 23'd0};
    e8 = 8'(e);
    return {tag, 4'b0000, s, e8, quot_frac(a, b)};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int r;
    r = int'($urandom_range(0, 15));
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    case (r)
      0:       e = 8'd0;
      1:       begin e = 8'hFF; f = 23'd0; end
      2:       begin e = 8'hFF; f = f | 23'd1; end
      3, 4:    e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(110, 145));
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a handshake seen between edges completes at the next rising edge.
  always begin
    @(negedge clk); #1;
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (expq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got tag %0d data %h, expected none",
                 bus.res_tag, bus.res_data);
      end else begin
        check("result", 64'({bus.res_tag, bus.res_flags, bus.res_data}), 64'(expq.pop_front()));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input exp_t e);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no req_ready, expected accept of tag %0d", tag);
    end else begin
      expq.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic send_exp(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                          input logic [31:0] data, input logic [3:0] flags);
    send(a, b, tag, {tag, flags, data});
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] tag);
    logic [31:0] a, b;
    a = rand_fp(); b = rand_fp();
    send(a, b, tag, ref_div(a, b, tag));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.res_ready = 1'b1;
    while (expq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (expq.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", expq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data",  64'(bus.res_data),  64'd0);
    check("rst_res_tag",   64'(bus.res_tag),   64'd0);
    check("rst_res_flags", 64'(bus.res_flags), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Basic quotient and first-result latency.
    bus.res_ready = 1'b1;
    send_exp(32'h40C00000, 32'h40000000, 4'd3, 32'h40400000, 4'b0000);
    idle(); #1; check("lat_t1", 64'(bus.res_valid), 64'd0);
    @(negedge clk); #1; check("lat_t2", 64'(bus.res_valid), 64'd0);
    @(negedge clk); #1; check("lat_t3", 64'(bus.res_valid), 64'd1);
    drain();

    send_exp(32'h3F800000, 32'h40400000, 4'd1, 32'h3EAAAAAA, 4'b0000);
    send_exp(32'h3F800000, 32'h00000000, 4'd2, 32'h7F800000, 4'b0100);
    send_exp(32'h00000000, 32'h00000000, 4'd3, 32'h7FC00000, 4'b1000);
    send_exp(32'hFF800000, 32'h40000000, 4'd4, 32'hFF800000, 4'b0000);
    send_exp(32'h40000000, 32'h7F800000, 4'd5, 32'h00000000, 4'b0000);
    send_exp(32'h7F000000, 32'h00800000, 4'd6, 32'h7F800000, 4'b0010);
    send_exp(32'h00800000, 32'h7F000000, 4'd7, 32'h00000000, 4'b0001);
    idle();
    drain();

    // Credit limit with the consumer stalled.
    bus.res_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_a = 32'h40C00000; bus.req_b = 32'h40000000;
      bus.req_tag = 4'(acc);
      if (c >= 4) check("credit_ready_low", 64'(bus.req_ready), 64'd0);
      if (bus.req_ready) begin
        expq.push_back({4'(acc), 4'b0000, 32'h40400000});
        acc++;
      end
    end
    check("credit_accepts", 64'(acc), 64'd4);
    @(negedge clk);
    bus.res_ready = 1'b1;
    fork
      for (int k = 0; k < 4; k++) begin
        #1; check("drain_back_to_back", 64'(bus.res_valid), 64'd1);
        @(negedge clk);
      end
      begin
        send_exp(32'h40C00000, 32'h40000000, 4'd4, 32'h40400000, 4'b0000);
        send_exp(32'h40C00000, 32'h40000000, 4'd5, 32'h40400000, 4'b0000);
        idle();
      end
    join
    drain();

    // Reset with two results still inside the divider.
    send_exp(32'h40C00000, 32'h40000000, 4'd10, 32'h40400000, 4'b0000);
    send_exp(32'h3F800000, 32'h40400000, 4'd11, 32'h3EAAAAAA, 4'b0000);
    @(negedge clk);
    bus.req_valid = 1'b0; rst_n = 1'b0; expq.delete();
    @(negedge clk); rst_n = 1'b1; #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("post_rst_no_result", 64'(bus.res_valid), 64'd0);
      @(negedge clk); #1;
    end
    send_exp(32'h3F800000, 32'h40400000, 4'd12, 32'h3EAAAAAA, 4'b0000);
    idle();
    drain();

    // Randomised operands with a randomly stalling consumer.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) send_rand(4'(i));
        idle();
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(negedge clk);
        bus.res_ready = ($urandom_range(0, 3) != 0);
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
